// File: rtl/cic_comp_fir.sv
// Inverse-sinc FIR compensator ahead of the CIC interpolator.
// One shared multiplier-accumulator walks all taps per input sample; the result
// is rounded half-up, saturated and presented with a one-cycle strobe.
module cic_comp_fir #(
  parameter int BITLEN    = 16,
  parameter int NTAPS     = 15,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter logic [NTAPS-1:0][COEF_W-1:0] COEFS =
    (NTAPS*COEF_W)'(1 << COEF_FRAC) << (7*COEF_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_stb,
  input  logic [BITLEN-1:0] in,
  output logic [BITLEN-1:0] out,
  output logic              out_stb,
  output logic              busy,
  output logic              overrun
);

  localparam int ACC_W  = BITLEN + COEF_W + $clog2(NTAPS);
  localparam int PROD_W = BITLEN + COEF_W;
  localparam int PTR_W  = $clog2(NTAPS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NTAPS - 1);

  // Rounding constant and output clamp limits, one bit wider than acc so the
  // half-LSB addition can never wrap.
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W:0] MAXV =
    {{(ACC_W-BITLEN+2){1'b0}}, {(BITLEN-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV =
    {{(ACC_W-BITLEN+2){1'b1}}, {(BITLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state_q;
  logic signed [BITLEN-1:0]  dline_q [NTAPS];
  logic        [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic        [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic        [PTR_W-1:0]   tap_q;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [BITLEN-1:0]  out_q, out_d;
  logic                      out_stb_q;
  logic                      busy_q;
  logic                      overrun_q;

  logic signed [BITLEN-1:0]  x_s;
  logic signed [COEF_W-1:0]  h_s;
  logic signed [PROD_W-1:0]  prod_s;

  // Round half up by COEF_FRAC bits, then clamp to the output range.
  function automatic logic signed [BITLEN-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(a) + HALF;
    t = t >>> COEF_FRAC;
    if (t > MAXV)      return MAXV[BITLEN-1:0];
    else if (t < MINV) return MINV[BITLEN-1:0];
    else               return t[BITLEN-1:0];
  endfunction

  // Datapath: current tap product, next accumulator, pointer wrap and output value.
  always_comb begin
    x_s      = dline_q[rd_ptr_q];
    h_s      = $signed(COEFS[tap_q]);
    prod_s   = PROD_W'(x_s) * PROD_W'(h_s);
    acc_d    = acc_q + ACC_W'(prod_s);
    wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - PTR_W'(1);
    out_d    = round_sat(acc_q);
  end

  // Sequencer: IDLE captures a sample, MAC walks the taps newest-first, OUT publishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      for (int j = 0; j < NTAPS; j++) dline_q[j] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      out_stb_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (ena) begin
      out_stb_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_stb) begin
            dline_q[wr_ptr_q] <= $signed(in);
            rd_ptr_q          <= wr_ptr_q;
            wr_ptr_q          <= wr_ptr_d;
            acc_q             <= '0;
            tap_q             <= '0;
            busy_q            <= 1'b1;
            state_q           <= MAC;
          end
        end
        MAC: begin
          acc_q    <= acc_d;
          tap_q    <= tap_q + PTR_W'(1);
          rd_ptr_q <= rd_ptr_d;
          if (tap_q == LAST) state_q <= OUT;
        end
        OUT: begin
          out_q     <= out_d;
          out_stb_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A strobe arriving while a sample is in flight is lost; remember that.
      if (in_stb && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  assign out     = out_q;
  assign out_stb = out_stb_q & ena;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
